out_writer: RTL and testbench

OUT_WRITER -- requirements
Module: out_writer

---
 rtl/out_writer.sv | 122 ++++++++++++
 tb/tb_out_writer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/out_writer.sv
// Packs a row-major stream of 8-bit result elements into 32-bit output-buffer
// words, with each row starting on its own word boundary (stride 1..3 words).
module out_writer #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [3:0]        m,
  input  logic [3:0]        n,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state;
  logic [3:0]          m_q;
  logic [3:0]          n_q;
  logic [3:0]          row_q;
  logic [3:0]          col_q;
  logic [1:0]          off_q;
  logic [ADDR_W-1:0]   base_q;
  logic [DATA_W-1:0]   pack_q;

  logic [3:0]          n_clamp;
  logic [1:0]          off_new;
  logic [1:0]          lane;
  logic                last_col;
  logic                last_row;
  logic                xfer;
  logic [DATA_W-1:0]   word;
  logic [ADDR_W-1:0]   addr;

  always_comb begin
    n_clamp  = (n > 4'd12) ? 4'd12 : n;
    // Words per row = ceil(n/4); 12+3 still fits in 4 bits.
    off_new  = 2'((n_clamp + 4'd3) >> 2);
    lane     = col_q[1:0];
    last_col = (col_q == n_q - 4'd1);
    last_row = (row_q == m_q - 4'd1);
    xfer     = in_valid && in_ready;
    word     = pack_q;
    word[{lane, 3'b000} +: 8] = in_data;
    addr     = base_q + {{(ADDR_W-2){1'b0}}, col_q[3:2]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      m_q      <= '0;
      n_q      <= '0;
      row_q    <= '0;
      col_q    <= '0;
      off_q    <= '0;
      base_q   <= '0;
      pack_q   <= '0;
      in_ready <= 1'b0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      done     <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            m_q    <= m;
            n_q    <= n_clamp;
            off_q  <= off_new;
            row_q  <= '0;
            col_q  <= '0;
            base_q <= '0;
            pack_q <= '0;
            if (m == 4'd0 || n == 4'd0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state    <= RUN;
              in_ready <= 1'b1;
            end
          end
        end
        RUN: begin
          if (xfer) begin
            if (lane == 2'd3 || last_col) begin
              wr_en   <= 1'b1;
              wr_addr <= addr;
              wr_data <= word;
              pack_q  <= '0;
            end else begin
              pack_q <= word;
            end
            if (last_col) begin
              col_q  <= '0;
              row_q  <= row_q + 4'd1;
              base_q <= base_q + {{(ADDR_W-2){1'b0}}, off_q};
              // Final write and done are issued on the same cycle.
              if (last_row) begin
                state    <= DONE;
                in_ready <= 1'b0;
                done     <= 1'b1;
              end
            end else begin
              col_q <= col_q + 4'd1;
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_out_writer.sv
// Directed bench for out_writer: expected writes are queued from a reference
// packing model and popped as the DUT issues wr_en.
module tb_out_writer;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [3:0]        m;
  logic [3:0]        n;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              done;

  out_writer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .start(start), .m(m), .n(n),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  logic exp_done_wr = 1'b1;
  logic [ADDR_W+DATA_W-1:0] exp_q[$];

  // Write monitor: sampled mid-cycle, away from the rising edge.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      logic [ADDR_W+DATA_W-1:0] e;
      wr_cnt++;
      checks++;
      assert (exp_q.size() > 0)
      else begin
        errors++;
        $error("FAIL unexpected_write: addr=%0d data=%h required no write", wr_addr, wr_data);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        assert ({wr_addr, wr_data} === e)
        else begin
          errors++;
          $error("FAIL write_word: got addr=%0d data=%h required addr=%0d data=%h",
                 wr_addr, wr_data, e[ADDR_W+DATA_W-1:DATA_W], e[DATA_W-1:0]);
        end
      end
    end
    if (done === 1'b1) begin
      done_cnt++;
      checks++;
      assert (wr_en === exp_done_wr)
      else begin
        errors++;
        $error("FAIL done_with_wr: wr_en=%b required %b", wr_en, exp_done_wr);
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: got %0h required %0h", tag, obs, exp);
    end
  endtask

  // Reference packing: row stride ceil(n/4) words, lane c%4, row ends flush.
  task automatic model_job(input int mm, input int nn, input logic [7:0] first);
    int ne, off;
    logic [DATA_W-1:0] w;
    logic [7:0] b;
    ne  = (nn > 12) ? 12 : nn;
    off = (ne <= 4) ? 1 : (ne <= 8) ? 2 : 3;
    b   = first;
    for (int r = 0; r < mm; r++) begin
      w = '0;
      for (int c = 0; c < ne; c++) begin
        w[8*(c%4) +: 8] = b;
        b++;
        if (c % 4 == 3 || c == ne - 1) begin
          exp_q.push_back({ADDR_W'(r*off + c/4), w});
          w = '0;
        end
      end
    end
  endtask

  task automatic start_job(input logic [3:0] mm, input logic [3:0] nn);
    start = 1'b1; m = mm; n = nn;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Drive one byte, optionally after idle cycles; strict demands no stall.
  task automatic send_byte(input logic [7:0] b, input int gap, input bit strict);
    int tries;
    logic ok;
    in_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    in_valid = 1'b1;
    in_data  = b;
    tries    = 0;
    ok       = 1'b0;
    while (!ok && tries < 50) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk); #1;
      tries++;
    end
    in_valid = 1'b0;
    if (!ok) check("byte_accept_timeout", 64'(ok), 64'd1);
    else if (strict) check("no_stall", 64'(tries), 64'd1);
  endtask

  task automatic wait_done(input string tag);
    int prev;
    prev = done_cnt;
    for (int i = 0; i < 200 && done_cnt == prev; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    check({tag, "_done_pulses"}, 64'(done_cnt - prev), 64'd1);
    check({tag, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
    check({tag, "_in_ready_low"}, 64'(in_ready), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int w0;
    rst = 1'b1; start = 1'b0; m = '0; n = '0; in_valid = 1'b0; in_data = '0;
    @(negedge clk);
    check("reset_in_ready", 64'(in_ready), 64'd0);
    check("reset_wr_en",    64'(wr_en),    64'd0);
    check("reset_wr_addr",  64'(wr_addr),  64'd0);
    check("reset_wr_data",  64'(wr_data),  64'd0);
    check("reset_done",     64'(done),     64'd0);
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;

    // Bytes offered while idle must not be consumed.
    in_valid = 1'b1; in_data = 8'hEE;
    repeat (3) begin @(posedge clk); #1; end
    in_valid = 1'b0;

    // m=2, n=4, continuous.
    exp_done_wr = 1'b1;
    model_job(2, 4, 8'h01);
    check("m2n4_model_first", exp_q[0], {8'd0, 32'h04030201});
    start_job(4'd2, 4'd4);
    for (int i = 0; i < 8; i++) send_byte(8'(8'h01 + i), 0, 1'b1);
    wait_done("m2n4");

    // m=1, n=6, zero padded second word.
    model_job(1, 6, 8'h11);
    check("m1n6_model_pad", exp_q[1], {8'd1, 32'h00001615});
    start_job(4'd1, 4'd6);
    for (int i = 0; i < 6; i++) send_byte(8'(8'h11 + i), 0, 1'b1);
    wait_done("m1n6");

    // m=3, n=12, random valid gaps.
    w0 = wr_cnt;
    model_job(3, 12, 8'h00);
    start_job(4'd3, 4'd12);
    for (int i = 0; i < 36; i++) send_byte(8'(i), $urandom_range(0, 2), 1'b0);
    wait_done("m3n12");
    check("m3n12_writes", 64'(wr_cnt - w0), 64'd9);

    // Empty job: done one cycle after start, no writes.
    w0 = wr_cnt;
    exp_done_wr = 1'b0;
    start = 1'b1; m = 4'd0; n = 4'd5;
    @(posedge clk); #1;
    start = 1'b0;
    check("m0_done_next_cycle", 64'(done), 64'd1);
    check("m0_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    check("m0_done_one_cycle", 64'(done), 64'd0);
    check("m0_no_writes", 64'(wr_cnt - w0), 64'd0);
    exp_done_wr = 1'b1;
    repeat (2) begin @(posedge clk); #1; end

    // Reset after three bytes of m=1, n=8 aborts with no write.
    w0 = wr_cnt;
    start_job(4'd1, 4'd8);
    for (int i = 0; i < 3; i++) send_byte(8'(8'hA0 + i), 0, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_in_ready", 64'(in_ready), 64'd0);
    check("abort_wr_en", 64'(wr_en), 64'd0);
    @(posedge clk); #1; rst = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check("abort_no_writes", 64'(wr_cnt - w0), 64'd0);
    model_job(1, 8, 8'hB0);
    start_job(4'd1, 4'd8);
    for (int i = 0; i < 8; i++) send_byte(8'(8'hB0 + i), 0, 1'b1);
    wait_done("after_abort");

    // n=15 clamps to 12; start and m/n changes during RUN ignored.
    model_job(2, 15, 8'h40);
    check("n15_model_addr5", exp_q[5][ADDR_W+DATA_W-1:DATA_W], 64'd5);
    start_job(4'd2, 4'd15);
    start = 1'b1; m = 4'd0; n = 4'd1;
    for (int i = 0; i < 24; i++) send_byte(8'(8'h40 + i), 0, 1'b1);
    start = 1'b0;
    wait_done("n15");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
